// File: rtl/eth_cfg_pkg.sv
// Shared definitions for the ethmac configuration sequencer: register offsets,
// FSM states and the fixed programming table.
package eth_cfg_pkg;

  localparam logic [7:0] ADR_MODER      = 8'h00;
  localparam logic [7:0] ADR_INT_SOURCE = 8'h04;
  localparam logic [7:0] ADR_INT_MASK   = 8'h08;
  localparam logic [7:0] ADR_IPGT       = 8'h0C;
  localparam logic [7:0] ADR_TX_BD_NUM  = 8'h20;
  localparam logic [7:0] ADR_MAC_ADDR0  = 8'h40;
  localparam logic [7:0] ADR_MAC_ADDR1  = 8'h44;

  localparam logic [3:0] LAST_STEP = 4'd8;

  typedef enum logic [2:0] {StIdle, StReq, StNext, StDone, StFail} state_e;

  typedef struct packed {
    logic [7:0]  adr;
    logic [31:0] dat;
    logic        we;
  } step_t;

  // MODER is first written with TXEN/RXEN clear so the core is quiet while configured.
  function automatic step_t step_entry(input logic [3:0]  step,
                                       input logic [31:0] moder_run,
                                       input logic [31:0] int_mask,
                                       input logic [31:0] ipgt,
                                       input logic [47:0] mac_addr,
                                       input logic [7:0]  tx_bd_num);
    step_t e;
    e.adr = ADR_MODER;
    e.dat = 32'h0;
    e.we  = 1'b1;
    case (step)
      4'd0: e.dat = moder_run & ~32'h3;
      4'd1: begin e.adr = ADR_INT_SOURCE; e.dat = 32'h7F; end
      4'd2: begin e.adr = ADR_INT_MASK;   e.dat = int_mask; end
      4'd3: begin e.adr = ADR_IPGT;       e.dat = ipgt; end
      4'd4: begin e.adr = ADR_MAC_ADDR0;  e.dat = mac_addr[31:0]; end
      4'd5: begin e.adr = ADR_MAC_ADDR1;  e.dat = {16'h0, mac_addr[47:32]}; end
      4'd6: begin e.adr = ADR_TX_BD_NUM;  e.dat = {24'h0, tx_bd_num}; end
      4'd7: e.dat = moder_run;
      default: e.we = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic is_granted(input state_e s);
    return (s == StDone) || (s == StFail);
  endfunction

endpackage

// File: rtl/eth_cfg_wb_mux.sv
// Two-source WISHBONE mux: the sequencer owns the ethmac slave until grant, then the host does.
module eth_cfg_wb_mux (
  input  logic        grant,
  input  logic [31:0] seq_adr,
  input  logic [31:0] seq_wdat,
  input  logic [3:0]  seq_sel,
  input  logic        seq_we,
  input  logic        seq_cyc,
  input  logic        seq_stb,
  input  logic [31:0] host_adr,
  input  logic [31:0] host_wdat,
  input  logic [3:0]  host_sel,
  input  logic        host_we,
  input  logic        host_cyc,
  input  logic        host_stb,
  input  logic [31:0] eth_rdat,
  input  logic        eth_ack,
  input  logic        eth_err,
  output logic [31:0] eth_adr,
  output logic [31:0] eth_wdat,
  output logic [3:0]  eth_sel,
  output logic        eth_we,
  output logic        eth_cyc,
  output logic        eth_stb,
  output logic [31:0] host_rdat,
  output logic        host_ack,
  output logic        host_err
);

  assign eth_adr   = grant ? host_adr  : seq_adr;
  assign eth_wdat  = grant ? host_wdat : seq_wdat;
  assign eth_sel   = grant ? host_sel  : seq_sel;
  assign eth_we    = grant ? host_we   : seq_we;
  assign eth_cyc   = grant ? host_cyc  : seq_cyc;
  assign eth_stb   = grant ? host_stb  : seq_stb;

  // Host sees nothing until granted, so its cycle stalls.
  assign host_rdat = grant ? eth_rdat : 32'h0;
  assign host_ack  = grant & eth_ack;
  assign host_err  = grant & eth_err;

endmodule

// File: rtl/eth_cfg_seq.sv
// Post-reset ethmac configuration sequencer; programs the register table, verifies MODER,
// then hands the WISHBONE slave port to the host.
module eth_cfg_seq
  import eth_cfg_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR   = 48'h0000_5A00_0001,
  parameter logic [31:0] MODER_RUN  = 32'h0000_A403,
  parameter logic [31:0] INT_MASK   = 32'h0000_007F,
  parameter logic [31:0] IPGT       = 32'h0000_0015,
  parameter logic [7:0]  TX_BD_NUM  = 8'h40,
  parameter int unsigned TIMEOUT    = 256,
  parameter int unsigned MAX_RETRY  = 3,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [3:0]  fail_step_o,
  input  logic [31:0] host_adr_i,
  input  logic [31:0] host_dat_i,
  input  logic [3:0]  host_sel_i,
  input  logic        host_we_i,
  input  logic        host_cyc_i,
  input  logic        host_stb_i,
  output logic [31:0] host_dat_o,
  output logic        host_ack_o,
  output logic        host_err_o,
  output logic [31:0] eth_adr_o,
  output logic [31:0] eth_dat_o,
  output logic [3:0]  eth_sel_o,
  output logic        eth_we_o,
  output logic        eth_cyc_o,
  output logic        eth_stb_o,
  input  logic [31:0] eth_dat_i,
  input  logic        eth_ack_i,
  input  logic        eth_err_i
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          redo_q, redo_d;
  logic          pend_q, pend_d;
  logic [3:0]    fail_step_q, fail_step_d;
  logic          first_q;
  logic          grant_q, grant_d;
  logic [31:0]   seq_adr_q, seq_adr_d, seq_dat_q, seq_dat_d;
  logic [3:0]    seq_sel_q, seq_sel_d;
  logic          seq_we_q, seq_we_d, seq_cyc_q, seq_cyc_d;
  step_t         entry;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      step_q      <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      redo_q      <= 1'b0;
      pend_q      <= 1'b0;
      fail_step_q <= '0;
      first_q     <= 1'b1;
      grant_q     <= 1'b0;
      seq_adr_q   <= '0;
      seq_dat_q   <= '0;
      seq_sel_q   <= '0;
      seq_we_q    <= 1'b0;
      seq_cyc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      redo_q      <= redo_d;
      pend_q      <= pend_d;
      fail_step_q <= fail_step_d;
      first_q     <= 1'b0;
      grant_q     <= grant_d;
      seq_adr_q   <= seq_adr_d;
      seq_dat_q   <= seq_dat_d;
      seq_sel_q   <= seq_sel_d;
      seq_we_q    <= seq_we_d;
      seq_cyc_q   <= seq_cyc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    redo_d      = redo_q;
    pend_d      = pend_q;
    fail_step_d = fail_step_q;
    unique case (state_q)
      StIdle: begin
        if (start_i || (AUTO_START && first_q)) begin
          state_d     = StReq;
          step_d      = '0;
          retry_d     = '0;
          timer_d     = '0;
          fail_step_d = '0;
        end
      end
      StReq: begin
        timer_d = timer_q + 1'b1;
        if (eth_ack_i) begin
          // A bad MODER readback is a configuration failure, not a bus fault: no retry.
          if (step_q == LAST_STEP && eth_dat_i != MODER_RUN) begin
            state_d     = StFail;
            fail_step_d = step_q;
          end else begin
            state_d = StNext;
            redo_d  = 1'b0;
          end
        end else if (eth_err_i || timer_q == TW'(TIMEOUT - 1)) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            redo_d  = 1'b1;
            state_d = StNext;
          end else begin
            state_d     = StFail;
            fail_step_d = step_q;
          end
        end
      end
      StNext: begin
        timer_d = '0;
        state_d = StReq;
        if (!redo_q) begin
          if (step_q == LAST_STEP) begin
            state_d = StDone;
          end else begin
            step_d  = step_q + 4'd1;
            retry_d = '0;
          end
        end
      end
      StDone, StFail: begin
        if (start_i) pend_d = 1'b1;
        // Restart waits for the host to close its cycle so grant never flips mid-access.
        if ((pend_q || start_i) && !host_cyc_i) begin
          state_d     = StReq;
          step_d      = '0;
          retry_d     = '0;
          timer_d     = '0;
          redo_d      = 1'b0;
          pend_d      = 1'b0;
          fail_step_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    entry     = step_entry(step_d, MODER_RUN, INT_MASK, IPGT, MAC_ADDR, TX_BD_NUM);
    seq_cyc_d = (state_d == StReq);
    seq_adr_d = seq_cyc_d ? {24'h0, entry.adr} : 32'h0;
    seq_dat_d = seq_cyc_d ? entry.dat : 32'h0;
    seq_we_d  = seq_cyc_d & entry.we;
    seq_sel_d = seq_cyc_d ? 4'hF : 4'h0;
    // Grant rises a cycle after DONE/FAIL (sequencer cyc already low) and drops on restart.
    grant_d   = is_granted(state_d) && is_granted(state_q);
    busy_o    = (state_q == StReq) || (state_q == StNext);
    done_o    = (state_q == StDone);
    fail_o    = (state_q == StFail);
  end

  assign fail_step_o = fail_step_q;

  eth_cfg_wb_mux u_mux (
    .grant     (grant_q),
    .seq_adr   (seq_adr_q),
    .seq_wdat  (seq_dat_q),
    .seq_sel   (seq_sel_q),
    .seq_we    (seq_we_q),
    .seq_cyc   (seq_cyc_q),
    .seq_stb   (seq_cyc_q),
    .host_adr  (host_adr_i),
    .host_wdat (host_dat_i),
    .host_sel  (host_sel_i),
    .host_we   (host_we_i),
    .host_cyc  (host_cyc_i),
    .host_stb  (host_stb_i),
    .eth_rdat  (eth_dat_i),
    .eth_ack   (eth_ack_i),
    .eth_err   (eth_err_i),
    .eth_adr   (eth_adr_o),
    .eth_wdat  (eth_dat_o),
    .eth_sel   (eth_sel_o),
    .eth_we    (eth_we_o),
    .eth_cyc   (eth_cyc_o),
    .eth_stb   (eth_stb_o),
    .host_rdat (host_dat_o),
    .host_ack  (host_ack_o),
    .host_err  (host_err_o)
  );

endmodule

// File: tb/tb_eth_cfg_seq.sv
// Bench for eth_cfg_seq: a register-file slave with configurable latency/err/no-ack,
// a bus monitor, and directed scenarios checked against the programming table.
module tb_eth_cfg_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start;
  logic [31:0] host_adr, host_dat, host_rdat;
  logic [3:0]  host_sel;
  logic        host_we, host_cyc, host_stb, host_ack, host_err;
  logic [31:0] eth_adr, eth_wdat, eth_rdat;
  logic [3:0]  eth_sel;
  logic        eth_we, eth_cyc, eth_stb, eth_ack, eth_err;
  logic        busy, done, fail;
  logic [3:0]  fail_step;

  always #5 clk = ~clk;

  eth_cfg_seq dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .fail_o      (fail),
    .fail_step_o (fail_step),
    .host_adr_i  (host_adr),
    .host_dat_i  (host_dat),
    .host_sel_i  (host_sel),
    .host_we_i   (host_we),
    .host_cyc_i  (host_cyc),
    .host_stb_i  (host_stb),
    .host_dat_o  (host_rdat),
    .host_ack_o  (host_ack),
    .host_err_o  (host_err),
    .eth_adr_o   (eth_adr),
    .eth_dat_o   (eth_wdat),
    .eth_sel_o   (eth_sel),
    .eth_we_o    (eth_we),
    .eth_cyc_o   (eth_cyc),
    .eth_stb_o   (eth_stb),
    .eth_dat_i   (eth_rdat),
    .eth_ack_i   (eth_ack),
    .eth_err_i   (eth_err)
  );

  // Expected register programming sequence.
  logic [31:0] exp_adr [9] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h40, 32'h44, 32'h20, 32'h00,
                               32'h00};
  logic [31:0] exp_dat [9] = '{32'hA400, 32'h7F, 32'h7F, 32'h15, 32'h5A00_0001, 32'h0,
                               32'h40, 32'hA403, 32'h0};
  logic        exp_we  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  // Slave behaviour knobs, written only by the stimulus block.
  int unsigned lat = 0, err_count = 0;
  logic [31:0] err_adr = 32'h0, noack_adr = 32'h0, force_val = 32'h0;
  bit          noack_en = 1'b0, force_en = 1'b0;

  logic [31:0] mem [64];
  int unsigned wait_n, err_given;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eth_ack   <= 1'b0;
      eth_err   <= 1'b0;
      eth_rdat  <= 32'h0;
      wait_n    <= 0;
      err_given <= 0;
    end else begin
      eth_ack <= 1'b0;
      eth_err <= 1'b0;
      if (eth_cyc && eth_stb && !eth_ack && !eth_err && !(noack_en && eth_adr == noack_adr)) begin
        if (wait_n < lat) begin
          wait_n <= wait_n + 1;
        end else begin
          wait_n <= 0;
          if (err_given < err_count && eth_adr == err_adr) begin
            eth_err   <= 1'b1;
            err_given <= err_given + 1;
          end else begin
            eth_ack <= 1'b1;
            if (eth_we) mem[eth_adr[7:2]] <= eth_wdat;
            eth_rdat <= (force_en && eth_adr == 32'h0) ? force_val : mem[eth_adr[7:2]];
          end
        end
      end else begin
        wait_n <= 0;
      end
    end
  end

  // Monitor: log acked transfers and count attempt starts per register.
  logic [68:0] obs [512];
  int unsigned obs_n = 0;
  int unsigned att [64];
  bit          prev_req = 1'b0;

  always @(posedge clk) begin
    if (eth_cyc && eth_stb && !prev_req) att[eth_adr[7:2]] <= att[eth_adr[7:2]] + 1;
    prev_req <= eth_cyc && eth_stb;
    if (eth_cyc && eth_stb && eth_ack) begin
      obs[obs_n[8:0]] <= {eth_adr, (eth_we ? eth_wdat : 32'h0), eth_we, eth_sel};
      obs_n <= obs_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic bit cond(input int s);
    case (s)
      0: return eth_cyc;
      1: return done;
      2: return fail;
      3: return busy;
      4: return eth_cyc && eth_adr == 32'h44;
      5: return eth_cyc && eth_adr == 32'h08;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int s, input int limit, output int n);
    n = 0;
    while (!cond(s) && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    start    = 1'b0;
    host_cyc = 1'b0;
    host_stb = 1'b0;
    host_we  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic host_access(input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                             input int limit, output logic [31:0] rdat, output bit acked,
                             output bit done_at);
    int n = 0;
    host_adr = adr;
    host_dat = wdat;
    host_we  = we;
    host_sel = 4'hF;
    host_cyc = 1'b1;
    host_stb = 1'b1;
    while (!host_ack && n < limit) begin
      @(negedge clk);
      n++;
    end
    acked    = host_ack;
    done_at  = done;
    rdat     = host_rdat;
    host_cyc = 1'b0;
    host_stb = 1'b0;
    host_we  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int unsigned base, a_cnt;
    logic [31:0] d, rd;
    bit ok, dn;

    start = 1'b0; host_adr = 32'h0; host_dat = 32'h0; host_sel = 4'h0;
    host_we = 1'b0; host_cyc = 1'b0; host_stb = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_eth", {eth_cyc, eth_stb, eth_we, eth_sel, eth_adr, eth_wdat}, 80'h0);
    check("reset_status", {busy, done, fail, fail_step}, 80'h0);
    check("reset_host", {host_ack, host_err, host_rdat}, 80'h0);

    // Auto-start, single-cycle ack: full table then done 27 cycles after first REQ.
    base = obs_n;
    rst  = 1'b0;
    wait_for(0, 5, n);
    check("s1_start", eth_cyc, 1);
    wait_for(1, 100, n);
    check("s1_done_cycles", n, 27);
    check("s1_count", obs_n - base, 9);
    for (int i = 0; i < 9; i++)
      check($sformatf("s1_step%0d", i), obs[base + i], {exp_adr[i], exp_dat[i], exp_we[i], 4'hF});
    check("s1_status", {busy, done, fail, fail_step}, {1'b0, 1'b1, 1'b0, 4'd0});

    // Two errors on MAC_ADDR0, then ack; random slave latency.
    do_reset();
    lat = $urandom_range(0, 2); err_adr = 32'h40; err_count = 2;
    base = obs_n; a_cnt = att[16];
    rst = 1'b0;
    wait_for(1, 400, n);
    check("s2_done", {done, fail}, 2'b10);
    check("s2_attempts", att[16] - a_cnt, 3);
    check("s2_count", obs_n - base, 9);
    check("s2_step4", obs[base + 4], {exp_adr[4], exp_dat[4], exp_we[4], 4'hF});

    // INT_MASK never acked: four full timeouts, then fail and grant.
    do_reset();
    err_count = 0; lat = $urandom_range(0, 1); noack_en = 1'b1; noack_adr = 32'h08;
    a_cnt = att[2];
    rst = 1'b0;
    wait_for(5, 50, n);
    check("s3_reach_step2", cond(5), 1);
    wait_for(2, 1100, n);
    check("s3_fail_cycles", n, 4 * 256 + 3);
    check("s3_status", {fail, done, busy, fail_step}, {1'b1, 1'b0, 1'b0, 4'd2});
    check("s3_attempts", att[2] - a_cnt, 4);
    d = $urandom;
    host_access(1'b1, 32'h48, d, 20, rd, ok, dn);
    check("s3_host_granted", ok, 1);

    // MODER readback mismatch: fail at step 8 without retry.
    do_reset();
    noack_en = 1'b0; force_en = 1'b1; force_val = 32'hA000; lat = 0;
    a_cnt = att[0];
    rst = 1'b0;
    wait_for(2, 200, n);
    check("s4_status", {fail, done, fail_step}, {1'b1, 1'b0, 4'd8});
    repeat (20) @(negedge clk);
    check("s4_moder_attempts", att[0] - a_cnt, 3);
    check("s4_hold", {fail, busy, fail_step}, {1'b1, 1'b0, 4'd8});

    // Host write issued mid-sequence stalls until done, then passes through.
    do_reset();
    force_en = 1'b0; lat = $urandom_range(0, 2);
    rst = 1'b0;
    repeat ($urandom_range(2, 10)) @(negedge clk);
    d = $urandom;
    host_access(1'b1, 32'h48, d, 400, rd, ok, dn);
    check("s5_host_wr_ack", ok, 1);
    check("s5_ack_after_done", dn, 1);
    check("s5_slave_data", mem[18], d);
    host_access(1'b0, 32'h48, 32'h0, 20, rd, ok, dn);
    check("s5_host_rd", {ok, rd}, {1'b1, d});

    // Restart held off while the host keeps its cycle open.
    host_adr = 32'h48; host_cyc = 1'b1; host_stb = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(5, 20)) @(negedge clk);
    check("s6_held", {busy, done}, 2'b01);
    base = obs_n;
    host_cyc = 1'b0;
    wait_for(3, 5, n);
    check("s6_restart_delay", n, 1);
    wait_for(1, 300, n);
    check("s6_done", {done, fail}, 2'b10);
    check("s6_first", obs[base], {exp_adr[0], exp_dat[0], exp_we[0], 4'hF});
    check("s6_count", obs_n - base, 9);

    // Reset in the middle of step 5 drops cyc at once; sequence reruns from step 0.
    do_reset();
    lat = 0;
    rst = 1'b0;
    wait_for(4, 40, n);
    check("s7_reach_step5", cond(4), 1);
    rst = 1'b1;
    #1;
    check("s7_async_drop", {eth_cyc, eth_stb, busy}, 3'b000);
    @(negedge clk);
    base = obs_n;
    rst = 1'b0;
    wait_for(1, 100, n);
    check("s7_done_cycles", n, 28);
    check("s7_count", obs_n - base, 9);
    check("s7_first", obs[base], {exp_adr[0], exp_dat[0], exp_we[0], 4'hF});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
